register_status_table_mp: RTL and testbench
===========================================

Name: register_status_table_mp

Overview:
- Parametrised successor of the single-CDB register status table in the Tomasulo dispatch path.
- Tracks, per architectural register, whether a result is pending and which reservation-station tag will produce it.
- Accepts NUM_CDB simultaneous common-data-bus broadcasts and produces per-channel register-file write enables.
- Adds NUM_CKPT branch checkpoints that are saved at dispatch and restored on misprediction.

Parameters:
- ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH.
- TAG_WIDTH, 6, tag width.
- NUM_CDB, 2, number of CDB broadcast channels.
- NUM_CKPT, 4, number of checkpoint slots.
- CKPT_ID_W, 2, checkpoint index width (clog2 of NUM_CKPT).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- write_enable0  in  1  dispatch claims destination register.
- write_address0  in  ADDR_WIDTH  destination register.
- write_data0  in  TAG_WIDTH  tag allocated to the destination.
- read_address0  in  ADDR_WIDTH  source register rs1.
- read_tag0  out  TAG_WIDTH  producer tag for rs1.
- read_valid0  out  1  1 = rs1 pending; consumer must wait for read_tag0.
- read_address1  in  ADDR_WIDTH  source register rs2.
- read_tag1  out  TAG_WIDTH  producer tag for rs2.
- read_valid1  out  1  1 = rs2 pending.
- cdb_tag  in  NUM_CDB*TAG_WIDTH  broadcast tags; channel c occupies bits [c*TAG_WIDTH +: TAG_WIDTH].
- cdb_valid  in  NUM_CDB  per-channel broadcast valid.
- RF_write_enable  out  NUM_CDB*NUM_REGS  bit [c*NUM_REGS+r] = write register r from CDB channel c.
- ckpt_save  in  1  snapshot state into slot ckpt_save_id.
- ckpt_save_id  in  CKPT_ID_W  destination slot for the snapshot.
- ckpt_restore  in  1  replace live state with slot ckpt_restore_id.
- ckpt_restore_id  in  CKPT_ID_W  slot to restore from.

Behaviour:
- State:
  - Live arrays pending[NUM_REGS] and tag[NUM_REGS].
  - Snapshot arrays ck_pending[NUM_CKPT][NUM_REGS] and ck_tag[NUM_CKPT][NUM_REGS].
- Reset (synchronous, clk edge with reset=1):
  - All live and snapshot pending bits = 0; all tags = 0.
  - Outputs therefore read_valid* = 0, read_tag* = 0, and RF_write_enable = 0 (no entry pending).
  - Reset overrides every other input in the same cycle.
  - Reset asserted mid-operation discards all pending state and checkpoints.
- Register 0: never pending. Writes to address 0 are ignored. Reads of address 0 return valid=0, tag=0. RF_write_enable bits for r=0 are always 0.
- CDB match (combinational): hit[c][r] = cdb_valid[c] & pending[r] & (tag[r] == cdb_tag[c]). RF_write_enable[c*NUM_REGS+r] = hit[c][r].
- Reads (combinational, same cycle):
  - read_valid = pending[addr] & ~(any hit on that addr), i.e. same-cycle CDB bypass.
  - read_tag = tag[addr] whenever read_valid=1, else 0.
  - Reads do not see the same-cycle write_enable0; that write becomes visible the next cycle.
- Live next-state, in priority order:
  1. Base image: if ckpt_restore, use the ck arrays of ckpt_restore_id; otherwise use the live arrays.
  2. CDB clear: any register whose tag matches a valid cdb_tag in the base image has pending cleared.
  3. Dispatch write: write_enable0 & ~ckpt_restore & (addr != 0) sets pending=1 and tag=write_data0. This overrides a same-cycle CDB clear of the same register.
  - write_enable0 during ckpt_restore is dropped, because the dispatching instruction is on the wrong path.
- Checkpoint save:
  - ckpt_save stores the live next-state (after steps 2–3) into slot ckpt_save_id, so a branch's snapshot includes writes dispatched in the same cycle.
  - ckpt_save is ignored while ckpt_restore is asserted.
- Snapshot maintenance:
  - Every cycle, in every slot not being written this cycle, clear ck_pending bits whose ck_tag matches any valid CDB tag.
  - This keeps completions between save and restore from being lost.
- Preconditions (bench asserts, no RTL handling): valid CDB tags are distinct across channels within a cycle; the upstream tag FIFO never assigns a live tag twice.
- Latency: reads and RF_write_enable are combinational (0 cycles); state updates take 1 cycle.

Test Plan:
- Reset, then read registers 3 and 0 -> read_valid0=0, read_tag0=0; RF_write_enable=0.
- Write reg 5 with tag 0x12; next cycle read reg 5 -> read_valid0=1, read_tag0=0x12. Then cdb_valid=2'b10, cdb_tag[ch1]=0x12 -> RF_write_enable bit (1*32+5)=1 and read_valid0=0 in the same cycle; the following cycle reg 5 is not pending.
- Same cycle: write reg 7 with tag 0x20 while CDB ch0 broadcasts reg 7's old tag 0x04 -> RF_write_enable[7]=1; next cycle reg 7 pending with tag 0x20.
- Write reg 1 with 0x01 and reg 2 with 0x02. ckpt_save slot 2 together with write reg 9 tag 0x09. Then write reg 1 with 0x11. CDB ch0 broadcasts 0x02. ckpt_restore slot 2 -> reg1 tag 0x01 pending, reg 9 pending with 0x09, reg 2 not pending.
- Two channels in one cycle clear reg 4 (tag 0x0A) and reg 6 (tag 0x0B) -> bits 4 and 32+6 set; both registers cleared next cycle.
- Write to reg 0 and a CDB with tag 0 -> reg 0 never pending; RF_write_enable bits 0 and 32 stay 0. Assert reset mid-sequence -> all state cleared next cycle.

Source files
------------

// File: rtl/register_status_table_mp.sv
// Register status table for Tomasulo dispatch: per-register pending/tag tracking,
// multi-channel CDB wakeup with same-cycle read bypass, and branch checkpoints.
module register_status_table_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int TAG_WIDTH  = 6,
  parameter int NUM_CDB    = 2,
  parameter int NUM_CKPT   = 4,
  parameter int CKPT_ID_W  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            write_enable0,
  input  logic [ADDR_WIDTH-1:0]           write_address0,
  input  logic [TAG_WIDTH-1:0]            write_data0,
  input  logic [ADDR_WIDTH-1:0]           read_address0,
  output logic [TAG_WIDTH-1:0]            read_tag0,
  output logic                            read_valid0,
  input  logic [ADDR_WIDTH-1:0]           read_address1,
  output logic [TAG_WIDTH-1:0]            read_tag1,
  output logic                            read_valid1,
  input  logic [NUM_CDB*TAG_WIDTH-1:0]    cdb_tag,
  input  logic [NUM_CDB-1:0]              cdb_valid,
  output logic [NUM_CDB*(2**ADDR_WIDTH)-1:0] RF_write_enable,
  input  logic                            ckpt_save,
  input  logic [CKPT_ID_W-1:0]            ckpt_save_id,
  input  logic                            ckpt_restore,
  input  logic [CKPT_ID_W-1:0]            ckpt_restore_id
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [NUM_REGS-1:0]  pending_q, pending_d;
  logic [TAG_WIDTH-1:0] tag_q [NUM_REGS];
  logic [TAG_WIDTH-1:0] tag_d [NUM_REGS];
  logic [NUM_REGS-1:0]  ck_pending_q [NUM_CKPT];
  logic [NUM_REGS-1:0]  ck_pending_d [NUM_CKPT];
  logic [TAG_WIDTH-1:0] ck_tag_q [NUM_CKPT][NUM_REGS];
  logic [TAG_WIDTH-1:0] ck_tag_d [NUM_CKPT][NUM_REGS];

  logic [NUM_REGS-1:0]  hit [NUM_CDB];
  logic [NUM_REGS-1:0]  any_hit;
  logic [NUM_REGS-1:0]  base_pending;
  logic [TAG_WIDTH-1:0] base_tag [NUM_REGS];
  logic                 save_en;

  // True when tag t is being broadcast on any valid CDB channel this cycle.
  function automatic logic cdb_match(input logic [TAG_WIDTH-1:0] t,
                                     input logic [NUM_CDB*TAG_WIDTH-1:0] tags,
                                     input logic [NUM_CDB-1:0] valids);
    logic m;
    m = 1'b0;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (valids[c] && (tags[c*TAG_WIDTH +: TAG_WIDTH] == t)) m = 1'b1;
    end
    return m;
  endfunction

  always_comb begin
    any_hit         = '0;
    RF_write_enable = '0;
    for (int c = 0; c < NUM_CDB; c++) begin
      hit[c] = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        hit[c][r] = cdb_valid[c] && pending_q[r] &&
                    (tag_q[r] == cdb_tag[c*TAG_WIDTH +: TAG_WIDTH]);
      end
      any_hit = any_hit | hit[c];
      RF_write_enable[c*NUM_REGS +: NUM_REGS] = hit[c];
    end
  end

  // Reads bypass a same-cycle broadcast so a consumer never waits on a tag already on the bus.
  assign read_valid0 = pending_q[read_address0] & ~any_hit[read_address0];
  assign read_tag0   = read_valid0 ? tag_q[read_address0] : '0;
  assign read_valid1 = pending_q[read_address1] & ~any_hit[read_address1];
  assign read_tag1   = read_valid1 ? tag_q[read_address1] : '0;

  always_comb begin
    base_pending = ckpt_restore ? ck_pending_q[ckpt_restore_id] : pending_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      base_tag[r]  = ckpt_restore ? ck_tag_q[ckpt_restore_id][r] : tag_q[r];
      pending_d[r] = (r != 0) && base_pending[r] && !cdb_match(base_tag[r], cdb_tag, cdb_valid);
      tag_d[r]     = base_tag[r];
    end
    // Dispatch beats a same-cycle completion of the old producer; dropped on restore (wrong path).
    if (write_enable0 && !ckpt_restore && (write_address0 != '0)) begin
      pending_d[write_address0] = 1'b1;
      tag_d[write_address0]     = write_data0;
    end
  end

  assign save_en = ckpt_save & ~ckpt_restore;

  always_comb begin
    for (int k = 0; k < NUM_CKPT; k++) begin
      ck_pending_d[k] = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (save_en && (ckpt_save_id == CKPT_ID_W'(k))) begin
          ck_pending_d[k][r] = pending_d[r];
          ck_tag_d[k][r]     = tag_d[r];
        end else begin
          ck_pending_d[k][r] = ck_pending_q[k][r] &&
                               !cdb_match(ck_tag_q[k][r], cdb_tag, cdb_valid);
          ck_tag_d[k][r]     = ck_tag_q[k][r];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) tag_q[r] <= '0;
      for (int k = 0; k < NUM_CKPT; k++) begin
        ck_pending_q[k] <= '0;
        for (int r = 0; r < NUM_REGS; r++) ck_tag_q[k][r] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      for (int r = 0; r < NUM_REGS; r++) tag_q[r] <= tag_d[r];
      for (int k = 0; k < NUM_CKPT; k++) begin
        ck_pending_q[k] <= ck_pending_d[k];
        for (int r = 0; r < NUM_REGS; r++) ck_tag_q[k][r] <= ck_tag_d[k][r];
      end
    end
  end

endmodule

// File: tb/tb_register_status_table_mp.sv
// Directed bench for register_status_table_mp: dispatch, CDB wakeup/bypass,
// checkpoint save/restore, register 0 and reset behaviour.
module tb_register_status_table_mp;

  localparam int AW = 5;
  localparam int TW = 6;
  localparam int NC = 2;
  localparam int NR = 32;

  logic                 clk;
  logic                 reset;
  logic                 write_enable0;
  logic [AW-1:0]        write_address0;
  logic [TW-1:0]        write_data0;
  logic [AW-1:0]        read_address0;
  logic [TW-1:0]        read_tag0;
  logic                 read_valid0;
  logic [AW-1:0]        read_address1;
  logic [TW-1:0]        read_tag1;
  logic                 read_valid1;
  logic [NC*TW-1:0]     cdb_tag;
  logic [NC-1:0]        cdb_valid;
  logic [NC*NR-1:0]     RF_write_enable;
  logic                 ckpt_save;
  logic [1:0]           ckpt_save_id;
  logic                 ckpt_restore;
  logic [1:0]           ckpt_restore_id;

  int checks = 0;
  int errors = 0;

  register_status_table_mp dut (
    .clk(clk), .reset(reset),
    .write_enable0(write_enable0), .write_address0(write_address0), .write_data0(write_data0),
    .read_address0(read_address0), .read_tag0(read_tag0), .read_valid0(read_valid0),
    .read_address1(read_address1), .read_tag1(read_tag1), .read_valid1(read_valid1),
    .cdb_tag(cdb_tag), .cdb_valid(cdb_valid), .RF_write_enable(RF_write_enable),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle();
    reset = 1'b0; write_enable0 = 1'b0; write_address0 = '0; write_data0 = '0;
    cdb_tag = '0; cdb_valid = '0;
    ckpt_save = 1'b0; ckpt_save_id = '0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
  endtask

  // Advance one edge; inputs set afterwards apply at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [TW-1:0] t);
    write_enable0 = 1'b1; write_address0 = a; write_data0 = t;
  endtask

  task automatic do_cdb(input logic [1:0] v, input logic [TW-1:0] t0, input logic [TW-1:0] t1);
    if (v == 2'b11 && t0 == t1) $error("bench drove duplicate CDB tags");
    cdb_valid = v; cdb_tag = {t1, t0};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    do_write(5'd3, 6'h2A);
    step();
    read_address0 = 5'd3; read_address1 = 5'd0;
    do_cdb(2'b11, 6'h2A, 6'h00);
    settle();
    checks++; if (read_valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid0 got %0h exp 0", read_valid0); end
    checks++; if (read_tag0 !== 6'h00) begin errors++; $display("FAIL reset_tag0 got %0h exp 0", read_tag0); end
    checks++; if (read_valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %0h exp 0", read_valid1); end
    checks++; if (RF_write_enable !== 64'h0) begin errors++; $display("FAIL reset_rfwe got %0h exp 0", RF_write_enable); end
  endtask

  task automatic test_write_read_cdb();
    do_write(5'd5, 6'h12);
    step();
    read_address0 = 5'd5;
    settle();
    checks++; if (read_valid0 !== 1'b1) begin errors++; $display("FAIL wr_valid got %0h exp 1", read_valid0); end
    checks++; if (read_tag0 !== 6'h12) begin errors++; $display("FAIL wr_tag got %0h exp 12", read_tag0); end
    do_cdb(2'b10, 6'h00, 6'h12);
    settle();
    checks++; if (RF_write_enable !== (64'h1 << 37)) begin errors++; $display("FAIL cdb1_rfwe got %0h exp %0h", RF_write_enable, 64'h1 << 37); end
    checks++; if (read_valid0 !== 1'b0) begin errors++; $display("FAIL cdb_bypass_valid got %0h exp 0", read_valid0); end
    checks++; if (read_tag0 !== 6'h00) begin errors++; $display("FAIL cdb_bypass_tag got %0h exp 0", read_tag0); end
    step();
    read_address0 = 5'd5;
    settle();
    checks++; if (read_valid0 !== 1'b0) begin errors++; $display("FAIL cdb_cleared got %0h exp 0", read_valid0); end
  endtask

  task automatic test_write_over_cdb();
    do_write(5'd7, 6'h04);
    step();
    do_write(5'd7, 6'h20);
    do_cdb(2'b01, 6'h04, 6'h00);
    settle();
    checks++; if (RF_write_enable !== (64'h1 << 7)) begin errors++; $display("FAIL wovr_rfwe got %0h exp %0h", RF_write_enable, 64'h1 << 7); end
    step();
    read_address0 = 5'd7; read_address1 = 5'd7;
    settle();
    checks++; if (read_valid0 !== 1'b1) begin errors++; $display("FAIL wovr_valid got %0h exp 1", read_valid0); end
    checks++; if (read_tag1 !== 6'h20) begin errors++; $display("FAIL wovr_tag got %0h exp 20", read_tag1); end
  endtask

  task automatic test_checkpoint();
    do_write(5'd1, 6'h01); step();
    do_write(5'd2, 6'h02); step();
    do_write(5'd9, 6'h09); ckpt_save = 1'b1; ckpt_save_id = 2'd2; step();
    do_write(5'd1, 6'h11); step();
    do_cdb(2'b01, 6'h02, 6'h00);
    settle();
    checks++; if (RF_write_enable !== (64'h1 << 2)) begin errors++; $display("FAIL ck_cdb_rfwe got %0h exp %0h", RF_write_enable, 64'h1 << 2); end
    step();
    // restore drops the wrong-path write and the save to slot 1
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd2;
    do_write(5'd10, 6'h3F); ckpt_save = 1'b1; ckpt_save_id = 2'd1;
    step();
    read_address0 = 5'd1; read_address1 = 5'd9;
    settle();
    checks++; if (read_valid0 !== 1'b1) begin errors++; $display("FAIL ck_r1_valid got %0h exp 1", read_valid0); end
    checks++; if (read_tag0 !== 6'h01) begin errors++; $display("FAIL ck_r1_tag got %0h exp 01", read_tag0); end
    checks++; if (read_valid1 !== 1'b1) begin errors++; $display("FAIL ck_r9_valid got %0h exp 1", read_valid1); end
    checks++; if (read_tag1 !== 6'h09) begin errors++; $display("FAIL ck_r9_tag got %0h exp 09", read_tag1); end
    read_address0 = 5'd2; read_address1 = 5'd10;
    settle();
    checks++; if (read_valid0 !== 1'b0) begin errors++; $display("FAIL ck_r2_valid got %0h exp 0", read_valid0); end
    checks++; if (read_valid1 !== 1'b0) begin errors++; $display("FAIL ck_r10_dropped got %0h exp 0", read_valid1); end
    read_address0 = 5'd7;
    settle();
    checks++; if (read_tag0 !== 6'h20) begin errors++; $display("FAIL ck_r7_tag got %0h exp 20", read_tag0); end
    // slot 1 was never saved, so it holds the reset image
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd1;
    step();
    read_address0 = 5'd7; read_address1 = 5'd1;
    settle();
    checks++; if (read_valid0 !== 1'b0) begin errors++; $display("FAIL ck1_r7_valid got %0h exp 0", read_valid0); end
    checks++; if (read_valid1 !== 1'b0) begin errors++; $display("FAIL ck1_r1_valid got %0h exp 0", read_valid1); end
  endtask

  task automatic test_dual_cdb();
    do_write(5'd4, 6'h0A); step();
    do_write(5'd6, 6'h0B); step();
    do_cdb(2'b11, 6'h0A, 6'h0B);
    read_address0 = 5'd4; read_address1 = 5'd6;
    settle();
    checks++; if (RF_write_enable !== ((64'h1 << 4) | (64'h1 << 38))) begin errors++; $display("FAIL dual_rfwe got %0h exp %0h", RF_write_enable, (64'h1 << 4) | (64'h1 << 38)); end
    checks++; if (read_valid0 !== 1'b0) begin errors++; $display("FAIL dual_bypass0 got %0h exp 0", read_valid0); end
    checks++; if (read_valid1 !== 1'b0) begin errors++; $display("FAIL dual_bypass1 got %0h exp 0", read_valid1); end
    step();
    read_address0 = 5'd4; read_address1 = 5'd6;
    do_cdb(2'b11, 6'h0A, 6'h0B);
    settle();
    checks++; if (RF_write_enable !== 64'h0) begin errors++; $display("FAIL dual_cleared_rfwe got %0h exp 0", RF_write_enable); end
    checks++; if ({read_valid0, read_valid1} !== 2'b00) begin errors++; $display("FAIL dual_cleared got %0h exp 0", {read_valid0, read_valid1}); end
  endtask

  task automatic test_reg0();
    do_write(5'd3, 6'h00); step();
    do_write(5'd0, 6'h00); step();
    do_cdb(2'b11, 6'h00, 6'h3E);
    read_address0 = 5'd0; read_address1 = 5'd3;
    settle();
    checks++; if (RF_write_enable !== (64'h1 << 3)) begin errors++; $display("FAIL reg0_rfwe got %0h exp %0h", RF_write_enable, 64'h1 << 3); end
    checks++; if ({read_valid0, read_tag0} !== 7'h0) begin errors++; $display("FAIL reg0_read got %0h exp 0", {read_valid0, read_tag0}); end
    step();
  endtask

  task automatic test_mid_reset();
    do_write(5'd8, 6'h15); step();
    do_write(5'd11, 6'h16); ckpt_save = 1'b1; ckpt_save_id = 2'd3; step();
    reset = 1'b1; do_write(5'd12, 6'h17); step();
    read_address0 = 5'd8; read_address1 = 5'd12;
    do_cdb(2'b11, 6'h15, 6'h16);
    settle();
    checks++; if ({read_valid0, read_valid1} !== 2'b00) begin errors++; $display("FAIL rst_mid_valid got %0h exp 0", {read_valid0, read_valid1}); end
    checks++; if (RF_write_enable !== 64'h0) begin errors++; $display("FAIL rst_mid_rfwe got %0h exp 0", RF_write_enable); end
    idle();
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd3;
    step();
    read_address0 = 5'd8; read_address1 = 5'd11;
    settle();
    checks++; if ({read_valid0, read_valid1} !== 2'b00) begin errors++; $display("FAIL rst_ckpt_cleared got %0h exp 0", {read_valid0, read_valid1}); end
  endtask

  initial begin
    idle();
    read_address0 = '0; read_address1 = '0;
    #2;
    test_reset();
    test_write_read_cdb();
    test_write_over_cdb();
    test_checkpoint();
    test_dual_cdb();
    test_reg0();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
